// File: rtl/seq_core_pkg.sv
// Shared definitions for the seq_core sequencer: instruction field positions, opcodes,
// FSM state type and register-file geometry.
package seq_core_pkg;

  localparam int unsigned REG_W = 16;
  localparam int unsigned NREG  = 4;

  localparam int unsigned IMM_MSB = 23;
  localparam int unsigned IMM_LSB = 8;
  localparam int unsigned S_BIT   = 7;
  localparam int unsigned A_MSB   = 6;
  localparam int unsigned A_LSB   = 5;
  localparam int unsigned B_MSB   = 4;
  localparam int unsigned B_LSB   = 3;
  localparam int unsigned OP_BIT  = 2;
  localparam int unsigned O_MSB   = 1;
  localparam int unsigned O_LSB   = 0;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_MOV = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } seq_state_t;

endpackage

// File: rtl/seq_regfile.sv
// 4x16 register file: operand A, operand B and debug read ports (combinational),
// one synchronous write port, asynchronous active-low reset.
module seq_regfile
  import seq_core_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_ra_sel,
  output logic [REG_W-1:0] o_ra_data,
  input  logic [1:0]       i_rb_sel,
  output logic [REG_W-1:0] o_rb_data,
  input  logic [1:0]       i_dbg_sel,
  output logic [REG_W-1:0] o_dbg_data,
  input  logic             i_we,
  input  logic [1:0]       i_wsel,
  input  logic [REG_W-1:0] i_wdata
);

  logic [REG_W-1:0] r_regs [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wsel] <= i_wdata;
    end
  end

  // Reads return the pre-write value, so o == a uses the old register contents.
  assign o_ra_data  = r_regs[i_ra_sel];
  assign o_rb_data  = r_regs[i_rb_sel];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/seq_core.sv
// Two-cycle FETCH/EXEC sequencer over a combinational instruction ROM.
// Define SEQ_CORE_RETIRE_CNT_EN to add the saturating o_retired counter port.
module seq_core
  import seq_core_pkg::*;
#(
  parameter int unsigned PROG_LEN = 23
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  output logic [7:0]       o_iaddr,
  input  logic [23:0]      i_idata,
  input  logic [1:0]       i_dbg_sel,
  output logic [REG_W-1:0] o_dbg_data,
  output logic             o_wb_valid,
  output logic             o_halted
`ifdef SEQ_CORE_RETIRE_CNT_EN
  ,
  output logic [15:0]      o_retired
`endif
);

  localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

  seq_state_t r_state, w_state_d;
  logic [7:0]  r_pc, w_pc_d;
  logic [23:0] r_ir, w_ir_d;
  logic        w_we;

  logic [REG_W-1:0] w_ra_data, w_rb_data, w_opb, w_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_ir    <= w_ir_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_ir_d    = r_ir;
    w_we      = 1'b0;
    unique case (r_state)
      StIdle:  w_state_d = StFetch;
      StFetch: begin
        if (i_run) begin
          w_ir_d    = i_idata;
          w_state_d = StExec;
        end
      end
      StExec: begin
        w_we      = 1'b1;
        w_pc_d    = r_pc + 8'd1;
        w_state_d = (r_pc == LAST_PC) ? StHalt : StFetch;
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_opb = r_ir[S_BIT] ? r_ir[IMM_MSB:IMM_LSB] : w_rb_data;

  always_comb begin
    w_wdata = w_ra_data;
    unique case (r_ir[OP_BIT])
      OP_ADD: w_wdata = w_ra_data + w_opb;
      OP_MOV: w_wdata = w_ra_data;
      default: w_wdata = w_ra_data;
    endcase
  end

  seq_regfile u_regfile (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ra_sel   (r_ir[A_MSB:A_LSB]),
    .o_ra_data  (w_ra_data),
    .i_rb_sel   (r_ir[B_MSB:B_LSB]),
    .o_rb_data  (w_rb_data),
    .i_dbg_sel  (i_dbg_sel),
    .o_dbg_data (o_dbg_data),
    .i_we       (w_we),
    .i_wsel     (r_ir[O_MSB:O_LSB]),
    .i_wdata    (w_wdata)
  );

  assign o_iaddr    = r_pc;
  assign o_wb_valid = w_we;
  assign o_halted   = (r_state == StHalt);

`ifdef SEQ_CORE_RETIRE_CNT_EN
  logic [15:0] r_retired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired <= '0;
    end else if (w_we && (r_retired != 16'hFFFF)) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign o_retired = r_retired;
`endif

endmodule

// File: doc/seq_core.md
# seq_core

Multi-cycle sequencer that drives the instruction-memory read port and executes the 24-bit program it returns. Fetches one word per instruction from the combinational instruction ROM, decodes the immediate/operand/opcode fields, and updates a 4×16-bit register file. It is the consumer and reader for the instruction memory, sitting between that ROM and the debug/status outputs of the C2 datapath.

## Interface
- `PROG_LEN`, default 23: number of valid instruction words. Execution halts after address `PROG_LEN-1` retires.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `run` input 1: level enable, sampled only in FETCH.
- `iaddr` output 8: instruction address to ROM. Equals `pc`.
- `idata` input 24: instruction word from ROM, combinational on `iaddr`.
- `dbg_sel` input 2: register index for debug read.
- `dbg_data` output 16: combinational `R[dbg_sel]`, pre-write value.
- `wb_valid` output 1: one-cycle pulse when a register write occurs.
- `halted` output 1: high once program end is reached.
- `retired` output 16: retired-instruction count. Present only with `SEQ_CORE_RETIRE_CNT_EN`.

## Operation
- Instruction fields:
  - `imm=idata[23:8]`
  - `s=idata[7]`
  - `a=idata[6:5]`
  - `b=idata[4:3]`
  - `op=idata[2]`
  - `o=idata[1:0]`
- Operand B = `s ? imm : R[b]`.
- `op=1` (ADD): `R[o] <= R[a] + B`, modulo 2^16, carry discarded.
- `op=0` (MOV): `R[o] <= R[a]`. `s`, `b` and `imm` are ignored.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE → FETCH on the first clock after reset release.
  - FETCH: if `run=1`, latch `idata` into `ir` and go to EXEC. Otherwise stay, holding `pc`.
  - EXEC: write `R[o]`, pulse `wb_valid`, `pc <= pc+1`. If `pc == PROG_LEN-1`, go to HALT. Otherwise go to FETCH.
  - HALT: sticky until reset. `iaddr` holds the last `pc+1`. No writes occur.
- `o == a` is legal: the read uses the pre-write value.
- `pc` is 8 bits. It is never allowed to wrap, because HALT is reached first (`PROG_LEN ≤ 256`).

## Timing
- Reset values:
  - `pc=0`, `iaddr=0`, `ir=0`
  - all `R=0`, so `dbg_data=0`
  - `wb_valid=0`, `halted=0`, `retired=0`
  - state = IDLE
- 2 cycles per instruction with `run` held high: FETCH, then EXEC.
- `wb_valid` is high during the EXEC cycle. The new register value is visible on `dbg_data` the cycle after.
- `halted` rises on the clock edge that leaves the final EXEC.
- Full program of `PROG_LEN` instructions: `halted` is high `2*PROG_LEN+1` cycles after reset release, assuming `run=1` throughout.
- `run` dropping during EXEC does not abort: the instruction completes and the core stalls at the next FETCH.
- Reset asserted mid-EXEC: the write is discarded and all state returns to its reset value immediately (async).
- `dbg_data` reads combinationally. A same-cycle write to `dbg_sel` still shows the old value.

## Configuration
- `SEQ_CORE_RETIRE_CNT_EN` defined: adds the `retired` port, a 16-bit counter incremented in every EXEC cycle. It saturates at 0xFFFF and resets to 0.
- Undefined: no port, no counter. All other behaviour is identical.

## Structure
- Package `seq_core_pkg` holds:
  - field bit-position constants (`IMM_MSB`/`IMM_LSB`, `S_BIT`, `A_*`, `B_*`, `OP_BIT`, `O_*`)
  - `OP_ADD=1'b1`, `OP_MOV=1'b0`
  - the state enum `seq_state_t`
  - `REG_W=16`, `NREG=4`
- One sub-module, `seq_regfile`:
  - 4×16 registers with async reset
  - two combinational read ports (`a` and `dbg_sel`)
  - a B-read port
  - one synchronous write port

## Test plan
- Reset release with `run=1` and the standard 23-word Fibonacci program → `halted` at cycle 47; final R0=0x0022, R1=0x0037, R2=0x0037, R3=0x0000; 23 `wb_valid` pulses.
- Word 0x000187 (ADD `s=1` `imm=1` `a=0` `o=3`) with R0=0xFFFF → R3=0x0000, wrap with no flag.
- `run` pulled low during the EXEC of `pc=4` → that write lands, `iaddr` holds 5, no further `wb_valid` until `run` returns; final results unchanged.
- MOV with `o==a` (0x000029, R1←R1) → R1 unchanged, `wb_valid` pulses once.
- `rst_n` asserted mid-program at `pc=9` → all registers and `pc` read 0 immediately; rerun completes identically.
- With `SEQ_CORE_RETIRE_CNT_EN`: after the full program `retired=23`, holding after HALT. Without the macro: build succeeds with no `retired` port.
